seq_alu: RTL
============

Name: seq_alu

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALUControl encoding produced by the ALU decoder. Used by the multi-cycle RISC-V core datapath.
- Add, sub, logic and compare ops complete in one execute cycle. Shifts (sll/srl/sra) use an iterative one-bit-per-cycle shifter to save area.
- Uses a start/busy/done handshake with the core controller.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, $clog2(WIDTH) = 5, width of the shift-amount field taken from SrcB.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge while busy=0.
- ALUControl  input  4  operation code (encoding below).
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- ALUResult  output  WIDTH  registered result; held until the next completion.
- Zero  output  1  high when ALUResult == 0.
- illegal  output  1  registered with done; high if ALUControl was unsupported.

Behaviour:
- ALUControl encodings:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0110 xor
  - 0101 slt (signed), 1101 sltu (unsigned)
  - 0100 sll, 0111 srl, 1111 sra
  - All other codes are illegal.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0, ALUResult=0, Zero=1, illegal=0
  - internal count and accumulator cleared.
- State machine: IDLE, EXEC, SHIFT. busy = (state != IDLE).
- IDLE:
  - On an edge e with start=1, latch ALUControl, SrcA and SrcB.
  - Shift op: acc<=SrcA, cnt<=SrcB[SHW-1:0], go to SHIFT.
  - Any other op (including illegal): go to EXEC.
  - start=0: stay in IDLE.
- EXEC, on the next edge:
  - ALUResult<=f(latched operands), done<=1, go to IDLE.
  - Arithmetic is modulo 2^WIDTH.
  - slt/sltu write 0 or 1, zero-extended.
  - Illegal code: ALUResult<=0, illegal<=1.
- SHIFT, each edge:
  - If cnt!=0: acc shifts one position (sll: left with 0 fill; srl: right with 0 fill; sra: right with acc[WIDTH-1] fill), cnt<=cnt-1.
  - If cnt==0: ALUResult<=acc, done<=1, go to IDLE.
- Latency:
  - Start sampled at edge e; done is high after edge e+1+n.
  - n = shamt for shifts, n = 0 otherwise.
  - shamt=0 therefore behaves like a single-cycle op and returns SrcA unchanged.
- done: high for exactly one cycle; cleared on the following edge. illegal follows the same timing as done.
- start while busy=1 is ignored and not queued. Operand and ALUControl changes while busy have no effect.
- Back-to-back: start may be asserted in the cycle done is high. That cycle is IDLE, so the new request is accepted.
- Zero is ~|ALUResult (combinational from the register); it updates only when ALUResult updates.
- Reset mid-operation aborts immediately. No done pulse is produced and ALUResult returns to 0.

Decomposition:
- Package alu_pkg holds:
  - localparams for all ten ALUControl codes, shared with alu_decoder so the encoding has one source;
  - the state encoding (IDLE/EXEC/SHIFT).
- One sub-module: serial_shifter.
  - Contents: acc, cnt, direction/arith control.
  - Interface: load, step; outputs acc and cnt_zero.
- The single-cycle combinational ops stay inline in seq_alu.

Test Plan:
- add/sub: start with 0000, A=5, B=7 -> done after e+1, ALUResult=12, Zero=0. Then 0001, A=3, B=5 -> 0xFFFFFFFE. Then 0001, A=9, B=9 -> 0, Zero=1.
- slt vs sltu: A=0xFFFFFFFF, B=1. Code 0101 -> 1; code 1101 -> 0.
- shifts:
  - sra A=0x80000000, B=31 -> busy for 32 cycles, done after e+32, result 0xFFFFFFFF.
  - srl same operands -> 0x00000001.
  - sll A=0x1, B=0x20 (shamt=0) -> done after e+1, result 0x1.
- handshake: pulse start during a 10-cycle sll -> ignored, exactly one done pulse. Then assert start in the done cycle -> second op accepted with no idle gap.
- illegal code 1000 -> done after e+1, ALUResult=0, Zero=1, illegal=1 for one cycle.
- reset: assert reset low mid-shift (cnt=12), asynchronously between edges -> outputs clear immediately, no done. After release, a fresh add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings, execute-unit state encoding and small decode helpers
// used by the multi-cycle execute unit and the ALU decoder.
package alu_pkg;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b1101;
    localparam logic [3:0] AluSll  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0111;
    localparam logic [3:0] AluSra  = 4'b1111;

    localparam logic [1:0] ShiftLeft       = 2'd0;
    localparam logic [1:0] ShiftRightLogic = 2'd1;
    localparam logic [1:0] ShiftRightArith = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShift
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == AluSll) || (op == AluSrl) || (op == AluSra);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            AluAdd, AluSub, AluAnd, AluOr, AluXor,
            AluSlt, AluSltu, AluSll, AluSrl, AluSra: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] shift_mode(input logic [3:0] op);
        case (op)
            AluSrl:  return ShiftRightLogic;
            AluSra:  return ShiftRightArith;
            default: return ShiftLeft;
        endcase
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Iterative shifter: moves the accumulator one bit per step until the count reaches zero.
module serial_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       load_mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [SHW-1:0]   load_cnt,
    output logic [WIDTH-1:0] acc,
    output logic             cnt_zero
);
    import alu_pkg::*;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load) begin
            acc_d  = load_val;
            cnt_d  = load_cnt;
            mode_d = load_mode;
        end else if (step && (cnt_q != '0)) begin
            case (mode_q)
                ShiftLeft:       acc_d = {acc_q[WIDTH-2:0], 1'b0};
                ShiftRightLogic: acc_d = {1'b0, acc_q[WIDTH-1:1]};
                ShiftRightArith: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                default:         acc_d = acc_q;
            endcase
            cnt_d = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= ShiftLeft;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign acc      = acc_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle arithmetic/logic/compare, serial shifts,
// start/busy/done handshake with the core controller.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);
    import alu_pkg::*;

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             accept;

    logic             sh_load, sh_step, sh_cnt_zero;
    logic [WIDTH-1:0] sh_acc;
    logic [WIDTH-1:0] exec_result;
    logic             lt_signed, lt_unsigned;

    serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .step      (sh_step),
        .load_mode (shift_mode(ALUControl)),
        .load_val  (SrcA),
        .load_cnt  (SrcB[SHW-1:0]),
        .acc       (sh_acc),
        .cnt_zero  (sh_cnt_zero)
    );

    assign lt_signed   = $signed(a_q) < $signed(b_q);
    assign lt_unsigned = a_q < b_q;

    always_comb begin
        exec_result = '0;
        case (op_q)
            AluAdd:  exec_result = a_q + b_q;
            AluSub:  exec_result = a_q - b_q;
            AluAnd:  exec_result = a_q & b_q;
            AluOr:   exec_result = a_q | b_q;
            AluXor:  exec_result = a_q ^ b_q;
            AluSlt:  exec_result = {{(WIDTH-1){1'b0}}, lt_signed};
            AluSltu: exec_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default: exec_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        accept    = 1'b0;
        sh_load   = 1'b0;
        sh_step   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept = 1'b1;
                    if (is_shift_op(ALUControl)) begin
                        sh_load = 1'b1;
                        state_d = StShift;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                result_d  = exec_result;
                illegal_d = !is_legal_op(op_q);
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            StShift: begin
                // Count reaching zero means the accumulator already holds the final value.
                if (sh_cnt_zero) begin
                    result_d = sh_acc;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    sh_step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            if (accept) begin
                op_q <= ALUControl;
                a_q  <= SrcA;
                b_q  <= SrcB;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign ALUResult = result_q;
    assign Zero      = ~|result_q;

endmodule
